instr_fetcher: RTL and testbench

- Front-end fetch stage directly upstream of the instruction processer; drives its address[2], instr[2] and hit[1:0] inputs and honours its stop backpressure.
- Generates the program counter and requests two consecutive 32-bit words per cycle from the instruction cache.
- Buffers returned pairs in a small FIFO and redirects on jumps/flushes from the back end.

---
 rtl/instr_fetcher.sv | 168 ++++++++++++++++
 tb/tb_instr_fetcher.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetcher.sv
// instr_fetcher: front-end fetch stage. Generates the program counter and
// requests a pair of consecutive 32-bit words from the I-cache each cycle.
// Returned pairs are buffered in a small FIFO. The FIFO head is presented
// through output registers to the instruction processor, which can hold it
// with stop. Jumps and flushes from the back end clear the buffer and insert
// a one-cycle bubble.
module instr_fetcher #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              cache_read,
  output logic [XLEN-1:0]   cache_address,
  input  logic [63:0]       cache_instr,
  input  logic [1:0]        cache_hit,
  input  logic              jmp_valid,
  input  logic [XLEN-1:0]   jmp_address,
  input  logic              flush,
  input  logic              stop,
  output logic [2*XLEN-1:0] address_out,
  output logic [63:0]       instr_out,
  output logic [1:0]        hit_out
);

  localparam int               PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_C    = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [XLEN-1:0]  WORD_BYTES = XLEN'(4);
  localparam logic [XLEN-1:0]  PAIR_BYTES = XLEN'(8);

  typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_t;

  state_t           state_reg, state_next;
  logic [XLEN-1:0]  pc_reg, pc_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] head_idx;
  logic [PTR_W:0]   count_reg, count_next;

  // Buffer storage; only the pointers carry reset state.
  logic [XLEN-1:0]  fifo_addr  [FIFO_DEPTH];
  logic [63:0]      fifo_instr [FIFO_DEPTH];
  logic [1:0]       fifo_hit   [FIFO_DEPTH];

  logic [XLEN-1:0]  out_addr0_reg, out_addr1_reg;
  logic [63:0]      out_instr_reg;
  logic [1:0]       out_hit_reg;

  logic             clear, push, pop, head_load;
  logic [XLEN-1:0]  jmp_target;

  assign clear      = jmp_valid | flush;
  assign push       = cache_read & cache_hit[0];   // 2'b10 counts as a miss
  // The displayed head is consumed whenever the consumer is not stalling.
  assign pop        = ~clear & ~stop & (out_hit_reg != 2'b00);
  assign jmp_target = jmp_address & ~XLEN'(3);

  assign cache_address = pc_reg;
  assign address_out   = {out_addr1_reg, out_addr0_reg};
  assign instr_out     = out_instr_reg;
  assign hit_out       = out_hit_reg;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= BOOT;
    else        state_reg <= state_next;
  end

  // FSM next state and request decision; requests only in RUN with room left.
  always_comb begin
    state_next = state_reg;
    cache_read = 1'b0;
    case (state_reg)
      BOOT:   state_next = RUN;
      BUBBLE: state_next = RUN;
      RUN: begin
        if (clear) state_next = BUBBLE;
        else if (count_reg < DEPTH_C) cache_read = 1'b1;
      end
      default: state_next = BOOT;
    endcase
  end

  // PC and FIFO bookkeeping; a jump wins over any same-cycle response.
  always_comb begin
    pc_next     = pc_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (jmp_valid)
      pc_next = jmp_target;
    else if (push)
      pc_next = pc_reg + ((cache_hit == 2'b11) ? PAIR_BYTES : WORD_BYTES);
    if (clear) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
      if (push && !pop)      count_next = count_reg + CNT_ONE;
      else if (pop && !push) count_next = count_reg - CNT_ONE;
    end
  end

  // Pointer, count and PC registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg     <= RESET_VECTOR;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      pc_reg     <= pc_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Buffer write of an accepted pair; partial hits keep only slot 0 valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_reg]  <= pc_reg;
      fifo_instr[wr_ptr_reg] <= cache_instr;
      fifo_hit[wr_ptr_reg]   <= (cache_hit == 2'b11) ? 2'b11 : 2'b01;
    end
  end

  // Select which entry the output register shows after this edge: the entry
  // behind the one being consumed, or the current head if nothing is consumed.
  always_comb begin
    head_idx  = rd_ptr_reg;
    head_load = 1'b0;
    if (clear) begin
      head_load = 1'b0;
    end else if (pop) begin
      head_idx  = rd_ptr_reg + PTR_ONE;
      head_load = (count_reg > CNT_ONE);
    end else begin
      head_load = (count_reg != '0);
    end
  end

  // Output register: copy of the FIFO head, all zero when nothing is buffered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_addr0_reg <= '0;
      out_addr1_reg <= '0;
      out_instr_reg <= '0;
      out_hit_reg   <= 2'b00;
    end else if (head_load) begin
      out_addr0_reg <= fifo_addr[head_idx];
      out_addr1_reg <= fifo_addr[head_idx] + WORD_BYTES;
      out_instr_reg <= fifo_instr[head_idx];
      out_hit_reg   <= fifo_hit[head_idx];
    end else begin
      out_addr0_reg <= '0;
      out_addr1_reg <= '0;
      out_instr_reg <= '0;
      out_hit_reg   <= 2'b00;
    end
  end

endmodule

// File: tb/tb_instr_fetcher.sv
// tb_instr_fetcher: scenario tasks plus a randomized run, checked against a
// queue-based reference model of the fetch stage.
`timescale 1ns/1ps
module tb_instr_fetcher;
  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cache_read;
  logic [31:0] cache_address;
  logic [63:0] cache_instr = '0;
  logic [1:0]  cache_hit = '0;
  logic        jmp_valid = 1'b0;
  logic [31:0] jmp_address = '0;
  logic        flush = 1'b0;
  logic        stop = 1'b0;
  logic [63:0] address_out;
  logic [63:0] instr_out;
  logic [1:0]  hit_out;

  instr_fetcher #(.XLEN(XLEN), .RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cache_read(cache_read), .cache_address(cache_address),
    .cache_instr(cache_instr), .cache_hit(cache_hit), .jmp_valid(jmp_valid),
    .jmp_address(jmp_address), .flush(flush), .stop(stop), .address_out(address_out),
    .instr_out(instr_out), .hit_out(hit_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [63:0] instr; logic [1:0] hit; } entry_t;

  // Reference model: queue of buffered pairs, fetch PC, idle cycles pending,
  // and whether the queue head is currently on the outputs.
  entry_t      q[$];
  logic [31:0] m_pc;
  int          m_idle;
  bit          m_shown;

  int          n_cmp = 0, n_fail = 0, n_cyc = 0;
  logic        exp_read, obs_read;
  logic [31:0] exp_caddr, obs_caddr;
  logic [63:0] exp_aout, exp_iout;
  logic [1:0]  exp_hout;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_outputs();
    if (m_shown) begin
      exp_aout = {q[0].addr + 32'd4, q[0].addr};
      exp_iout = q[0].instr;
      exp_hout = q[0].hit;
    end else begin
      exp_aout = '0;
      exp_iout = '0;
      exp_hout = 2'b00;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc = RV;
    m_idle = 1;
    m_shown = 0;
    model_outputs();
  endtask

  // One clock cycle: drive inputs at posedge+1, sample combinational outputs,
  // advance the model at the edge, return at posedge+1 with expectations set.
  task automatic drive_cycle(input bit j, input logic [31:0] ja, input bit fl,
                             input bit st, input logic [1:0] hit);
    bit clr, pp, ps;
    int n_before;
    entry_t e;
    jmp_valid = j; jmp_address = ja; flush = fl; stop = st; cache_hit = hit;
    cache_instr = {mem_word(m_pc + 32'd4), mem_word(m_pc)};
    exp_read  = (m_idle == 0) && (q.size() < DEPTH) && !j && !fl;
    exp_caddr = m_pc;
    #2;
    obs_read = cache_read;
    obs_caddr = cache_address;
    @(posedge clk);
    clr = j || fl;
    pp  = !clr && !st && m_shown;
    ps  = exp_read && hit[0];
    if (m_idle > 0) m_idle = 0;
    else if (clr)   m_idle = 1;
    if (clr) begin
      q.delete();
      m_shown = 0;
      if (j) m_pc = ja & ~32'd3;
    end else begin
      n_before = q.size();
      if (pp) void'(q.pop_front());
      m_shown = pp ? (q.size() > 0) : (n_before > 0);
      if (ps) begin
        e.addr = m_pc; e.instr = cache_instr; e.hit = (hit == 2'b11) ? 2'b11 : 2'b01;
        q.push_back(e);
        m_pc = m_pc + ((hit == 2'b11) ? 32'd8 : 32'd4);
      end
    end
    #1;
    model_outputs();
    n_cyc++;
    $display("cyc %0d j=%b fl=%b stop=%b chit=%b | req=%b caddr=%h | hit_out=%b addr0=%h",
             n_cyc, j, fl, st, hit, obs_read, obs_caddr, hit_out, address_out[31:0]);
  endtask

  task automatic test_reset();
    reset = 1'b0; stop = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({cache_read, cache_address, address_out, instr_out, hit_out} !== {1'b0, RV, 64'd0, 64'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: read=%b caddr=%h aout=%h hit=%b, required 0/%h/0/00",
               cache_read, cache_address, address_out, hit_out, RV);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 32'd0, 1'b0, 1'b1, 2'b11);
      n_cmp++;
      if (obs_read !== exp_read || obs_caddr !== exp_caddr) begin
        n_fail++;
        $display("FAIL reset_req: read/addr %b/%h, required %b/%h", obs_read, obs_caddr, exp_read, exp_caddr);
      end
      n_cmp++;
      if ({address_out, instr_out, hit_out} !== {exp_aout, exp_iout, exp_hout}) begin
        n_fail++;
        $display("FAIL reset_out: addr/instr/hit %h/%h/%b, required %h/%h/%b",
                 address_out, instr_out, hit_out, exp_aout, exp_iout, exp_hout);
      end
      if (i == 0) begin
        n_cmp++;
        if (obs_read !== 1'b0) begin
          n_fail++; $display("FAIL boot_no_req: read %b, required 0", obs_read);
        end
      end
      if (i >= 1 && i <= 3) begin
        n_cmp++;
        if (obs_read !== 1'b1 || obs_caddr !== RV + 32'(8 * (i - 1))) begin
          n_fail++;
          $display("FAIL boot_seq: read/addr %b/%h, required 1/%h", obs_read, obs_caddr, RV + 32'(8 * (i - 1)));
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (address_out[31:0] !== RV || hit_out !== 2'b11) begin
          n_fail++;
          $display("FAIL first_out: addr0/hit %h/%b, required %h/11", address_out[31:0], hit_out, RV);
        end
      end
    end
  endtask

  task automatic test_partial();
    logic [1:0] hits [4] = '{2'b11, 2'b11, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(i == 0, 32'h0000_001C, 1'b0, i >= 2, hits[i]);
      n_cmp++;
      if (obs_read !== exp_read || obs_caddr !== exp_caddr) begin
        n_fail++;
        $display("FAIL partial_req: read/addr %b/%h, required %b/%h", obs_read, obs_caddr, exp_read, exp_caddr);
      end
      n_cmp++;
      if ({address_out, instr_out, hit_out} !== {exp_aout, exp_iout, exp_hout}) begin
        n_fail++;
        $display("FAIL partial_out: addr/instr/hit %h/%h/%b, required %h/%h/%b",
                 address_out, instr_out, hit_out, exp_aout, exp_iout, exp_hout);
      end
    end
    n_cmp++;
    if (obs_caddr !== 32'h20 || hit_out !== 2'b01 || address_out !== {32'h20, 32'h1C}) begin
      n_fail++;
      $display("FAIL partial_hit: caddr=%h hit=%b aout=%h, required 20/01/%h", obs_caddr, hit_out,
               address_out, {32'h20, 32'h1C});
    end
  endtask

  task automatic test_miss();
    logic [1:0] hits [10] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    int reads40 = 0, shown40 = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(i == 0, 32'h0000_0040, 1'b0, 1'b0, hits[i]);
      n_cmp++;
      if (obs_read !== exp_read || obs_caddr !== exp_caddr) begin
        n_fail++;
        $display("FAIL miss_req: read/addr %b/%h, required %b/%h", obs_read, obs_caddr, exp_read, exp_caddr);
      end
      n_cmp++;
      if ({address_out, instr_out, hit_out} !== {exp_aout, exp_iout, exp_hout}) begin
        n_fail++;
        $display("FAIL miss_out: addr/instr/hit %h/%h/%b, required %h/%h/%b",
                 address_out, instr_out, hit_out, exp_aout, exp_iout, exp_hout);
      end
      if (obs_read && obs_caddr == 32'h40) reads40++;
      if (hit_out != 2'b00 && address_out[31:0] == 32'h40) shown40++;
    end
    n_cmp++;
    if (reads40 !== 4 || shown40 !== 1) begin
      n_fail++;
      $display("FAIL miss_retry: requests@40=%0d shown=%0d, required 4/1", reads40, shown40);
    end
  endtask

  task automatic test_stall();
    int reads = 0;
    bit resumed = 0;
    logic [31:0] emitted [$];
    logic [129:0] want;
    want = {32'h3004, 32'h3000, mem_word(32'h3004), mem_word(32'h3000), 2'b11};
    for (int i = 0; i < 14; i++) begin
      if (i >= 8 && hit_out != 2'b00) emitted.push_back(address_out[31:0]);
      drive_cycle(i == 0, 32'h0000_3000, 1'b0, i < 8, (i < 8) ? 2'b11 : 2'b00);
      n_cmp++;
      if (obs_read !== exp_read || obs_caddr !== exp_caddr) begin
        n_fail++;
        $display("FAIL stall_req: read/addr %b/%h, required %b/%h", obs_read, obs_caddr, exp_read, exp_caddr);
      end
      n_cmp++;
      if ({address_out, instr_out, hit_out} !== {exp_aout, exp_iout, exp_hout}) begin
        n_fail++;
        $display("FAIL stall_out: addr/instr/hit %h/%h/%b, required %h/%h/%b",
                 address_out, instr_out, hit_out, exp_aout, exp_iout, exp_hout);
      end
      if (i >= 2 && i < 8 && obs_read) reads++;
      if (i >= 8 && obs_read) resumed = 1;
      if (i >= 3 && i < 8) begin
        n_cmp++;
        if ({address_out, instr_out, hit_out} !== want) begin
          n_fail++;
          $display("FAIL stall_hold: outputs %h, required %h", {address_out, instr_out, hit_out}, want);
        end
      end
    end
    n_cmp++;
    if (reads !== 4 || !resumed) begin
      n_fail++; $display("FAIL stall_fill: requests=%0d resumed=%0d, required 4/1", reads, resumed);
    end
    n_cmp++;
    if (emitted.size() != 4) begin
      n_fail++; $display("FAIL stall_drain_count: emitted %0d, required 4", emitted.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (emitted[k] !== 32'h3000 + 32'(8 * k)) begin
          n_fail++; $display("FAIL stall_order: entry %0d addr %h, required %h", k, emitted[k], 32'h3000 + 32'(8 * k));
        end
      end
    end
  endtask

  task automatic test_jump();
    int stale = 0;
    for (int i = 0; i < 14; i++) begin
      drive_cycle(i == 0 || i == 5, (i == 0) ? 32'h5000 : 32'h2003, 1'b0, i < 6, 2'b11);
      n_cmp++;
      if (obs_read !== exp_read || obs_caddr !== exp_caddr) begin
        n_fail++;
        $display("FAIL jump_req: read/addr %b/%h, required %b/%h", obs_read, obs_caddr, exp_read, exp_caddr);
      end
      n_cmp++;
      if ({address_out, instr_out, hit_out} !== {exp_aout, exp_iout, exp_hout}) begin
        n_fail++;
        $display("FAIL jump_out: addr/instr/hit %h/%h/%b, required %h/%h/%b",
                 address_out, instr_out, hit_out, exp_aout, exp_iout, exp_hout);
      end
      if (i == 5) begin
        n_cmp++;
        if (obs_read !== 1'b0 || hit_out !== 2'b00) begin
          n_fail++; $display("FAIL jump_clear: read=%b hit=%b, required 0/00", obs_read, hit_out);
        end
      end
      if (i == 6) begin
        n_cmp++;
        if (obs_read !== 1'b0) begin
          n_fail++; $display("FAIL jump_bubble: read %b, required 0", obs_read);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if (obs_read !== 1'b1 || obs_caddr !== 32'h2000) begin
          n_fail++; $display("FAIL jump_target: read/addr %b/%h, required 1/2000", obs_read, obs_caddr);
        end
      end
      if (i >= 5 && hit_out != 2'b00 && (address_out[31:0] < 32'h2000 || address_out[31:0] >= 32'h2100)) stale++;
    end
    n_cmp++;
    if (stale !== 0) begin
      n_fail++; $display("FAIL jump_stale: %0d stale outputs, required 0", stale);
    end
  endtask

  task automatic test_reset_mid_miss();
    logic [1:0] hits [6] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00};
    for (int i = 0; i < 6; i++) begin
      drive_cycle(i == 0, 32'h0000_0070, 1'b0, 1'b1, hits[i]);
      n_cmp++;
      if (obs_read !== exp_read || obs_caddr !== exp_caddr ||
          {address_out, instr_out, hit_out} !== {exp_aout, exp_iout, exp_hout}) begin
        n_fail++;
        $display("FAIL rmiss_pre: read/addr/hit %b/%h/%b, required %b/%h/%b",
                 obs_read, obs_caddr, hit_out, exp_read, exp_caddr, exp_hout);
      end
    end
    n_cmp++;
    if (obs_caddr !== 32'h80 || hit_out !== 2'b11) begin
      n_fail++; $display("FAIL rmiss_setup: caddr=%h hit=%b, required 80/11", obs_caddr, hit_out);
    end
    cache_hit = 2'b00;
    #3;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({cache_read, cache_address, address_out, instr_out, hit_out} !== {1'b0, RV, 64'd0, 64'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL rmiss_async: read=%b caddr=%h aout=%h hit=%b, required 0/%h/0/00",
               cache_read, cache_address, address_out, hit_out, RV);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 32'd0, 1'b0, 1'b0, 2'b11);
      n_cmp++;
      if (obs_read !== exp_read || obs_caddr !== exp_caddr ||
          {address_out, instr_out, hit_out} !== {exp_aout, exp_iout, exp_hout}) begin
        n_fail++;
        $display("FAIL rmiss_restart: read/addr/hit %b/%h/%b, required %b/%h/%b",
                 obs_read, obs_caddr, hit_out, exp_read, exp_caddr, exp_hout);
      end
      if (i == 1) begin
        n_cmp++;
        if (obs_read !== 1'b1 || obs_caddr !== RV) begin
          n_fail++; $display("FAIL rmiss_vector: read/addr %b/%h, required 1/%h", obs_read, obs_caddr, RV);
        end
      end
    end
  endtask

  task automatic test_random();
    bit j, fl, st;
    logic [31:0] ja;
    logic [1:0] hit;
    for (int i = 0; i < 400; i++) begin
      j   = ($urandom_range(0, 19) == 0);
      fl  = ($urandom_range(0, 19) == 0);
      st  = ($urandom_range(0, 2) == 0);
      hit = 2'($urandom_range(0, 3));
      ja  = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
      drive_cycle(j, ja, fl, st, hit);
      n_cmp++;
      if (obs_read !== exp_read || obs_caddr !== exp_caddr) begin
        n_fail++;
        $display("FAIL rand_req: read/addr %b/%h, required %b/%h", obs_read, obs_caddr, exp_read, exp_caddr);
      end
      n_cmp++;
      if ({address_out, instr_out, hit_out} !== {exp_aout, exp_iout, exp_hout}) begin
        n_fail++;
        $display("FAIL rand_out: addr/instr/hit %h/%h/%b, required %h/%h/%b",
                 address_out, instr_out, hit_out, exp_aout, exp_iout, exp_hout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_partial();
    test_miss();
    test_stall();
    test_jump();
    test_reset_mid_miss();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
